fetch_pc_unit: RTL and testbench
================================

# fetch_pc_unit

Parametrised program-counter and next-PC selection unit at the front of the fetch stage. It holds the architectural fetch address and presents it to the instruction fetch path over a valid/ready handshake. On each cycle it advances sequentially by 4 or 2 bytes, or redirects to a trap, branch or predicted-return target. A small circular return-address stack (RAS) predicts `ret` targets.

## Interface
- `XLEN`, 32: address width in bits, minimum 16.
- `RESET_VECTOR`, 0: value of `fetch_pc` held during and out of reset. Must be aligned.
- `RAS_DEPTH`, 4: number of RAS entries, power of two, minimum 2.
- `C_EXT`, 0: 1 enables 2-byte steps and 2-byte alignment. 0 forces 4-byte alignment.

- `clk` in 1: single clock, all state updates on rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `fetch_valid` out 1: `fetch_pc` is a valid request.
- `fetch_ready` in 1: fetch path accepts `fetch_pc`. Low stalls sequential advance.
- `fetch_pc` out XLEN: current fetch address.
- `insn_len16` in 1: accepted instruction is 16-bit. Ignored when `C_EXT`=0.
- `trap_valid` in 1: trap/exception redirect request.
- `trap_vector` in XLEN: trap target.
- `br_valid` in 1: resolved branch/jump redirect request.
- `br_target` in XLEN: branch target.
- `call_push` in 1: decoded call. Push `call_ret_addr` onto the RAS.
- `call_ret_addr` in XLEN: return address to push.
- `ret_pop` in 1: decoded return. Redirect to the RAS top and pop it.
- `ras_empty` out 1: RAS holds no entries.
- `ret_miss` out 1: one-cycle pulse when `ret_pop` arrives with the RAS empty.
- `misalign_err` out 1: one-cycle pulse when an accepted redirect target is misaligned.

## Operation
- A handshake occurs when `fetch_valid && fetch_ready`.
- The next-PC source is chosen by fixed priority, evaluated every cycle:
  - 1. Trap: `trap_valid`.
  - 2. Branch: `br_valid`.
  - 3. Return: `ret_pop` with the RAS non-empty.
  - 4. Sequential: handshake. Step is +2 if `C_EXT && insn_len16`, else +4.
  - 5. Hold: none of the above.
- Redirects (priorities 1–3) are taken regardless of `fetch_ready`. They flush the current request.
- Sequential add wraps modulo 2^XLEN, with no error.
- Alignment check applies to trap and branch targets:
  - Misaligned means `target[1:0]!=0` when `C_EXT`=0, or `target[0]!=0` when `C_EXT`=1.
  - A misaligned target is loaded with the offending low bits cleared, and `misalign_err` pulses.
  - RAS targets are not checked.
- RAS is a circular buffer with top pointer `tp` and occupancy `cnt` (0..RAS_DEPTH):
  - Push writes at `tp+1` and advances `tp`. `cnt` saturates at RAS_DEPTH; the oldest entry is overwritten on wrap.
  - Pop reads the entry at `tp`, retreats `tp`, and decrements `cnt`.
  - Push and pop in the same cycle: the target is the old top, the old top is replaced by `call_ret_addr`, and `tp`/`cnt` are unchanged.
  - Pop on empty: no pointer change, `ret_miss` pulses, and no redirect (lower priority applies).
- RAS push/pop are performed even when the return redirect loses priority to trap/branch. Decode-side speculation is accepted; recovery is out of scope.
- Reset clears `cnt`/`tp` only. Entry contents are don't-care.

## Timing
- Reset (`rst_n`=0 at an edge) drives `fetch_pc`=RESET_VECTOR, `fetch_valid`=0, `ras_empty`=1, `ret_miss`=0, `misalign_err`=0.
- First edge with `rst_n`=1: `fetch_valid` goes to 1 and `fetch_pc` stays RESET_VECTOR. `fetch_valid` then remains 1 until the next reset.
- All outputs are registered. A redirect or sequential step requested in cycle N appears on `fetch_pc` in cycle N+1. Latency is 1 with no bubbles.
- `ret_miss` and `misalign_err` are asserted in cycle N+1 for exactly one cycle.
- `fetch_pc` and `fetch_valid` are stable while `fetch_ready`=0 and no redirect is present.
- Reset mid-operation overrides all requests in that cycle.

## Structure
- Package `pc_pkg`:
  - `next_pc_src_e` enum: `SRC_HOLD`, `SRC_SEQ`, `SRC_RET`, `SRC_BR`, `SRC_TRAP`.
  - Alignment-mask function parametrised on `C_EXT`.
  - Step constants `PC_STEP4`=4 and `PC_STEP2`=2.
- Sub-module `ras_stack` (params `XLEN`, `RAS_DEPTH`):
  - Owns the storage array, `tp` and `cnt`.
  - Interface: `push`, `push_data`, `pop`, `top_data`, `empty`, `pop_miss`.
- Top level: priority mux, alignment check, PC register and handshake logic.

## Test plan
- Reset then release, `fetch_ready`=1, RESET_VECTOR=0x100 → `fetch_pc` reads 0x100, 0x100, 0x104, 0x108. `fetch_valid` 0→1 on the first released edge.
- `fetch_ready`=0 for 3 cycles at pc 0x200 → `fetch_pc` holds 0x200. Ready high → 0x204. With `C_EXT`=1 and `insn_len16`=1 → 0x202.
- Same cycle `trap_valid` (0x800), `br_valid` (0x400), `ret_pop` with RAS non-empty → next `fetch_pc`=0x800. RAS still pops (`cnt` decremented).
- RAS_DEPTH=4: push 0x10, 0x20, 0x30, 0x40, 0x50, then 5 pops → targets 0x50, 0x40, 0x30, 0x20. Fifth pop gives `ret_miss`=1 and sequential advance.
- `br_target`=0x403 with `C_EXT`=0 → `fetch_pc`=0x400 and a one-cycle `misalign_err` pulse. With `C_EXT`=1 → 0x402 and a pulse.
- Mid-stream `rst_n`=0 with `br_valid`=1 and RAS holding 2 entries → `fetch_pc`=RESET_VECTOR, `fetch_valid`=0, `ras_empty`=1. A later `ret_pop` yields `ret_miss`.

Source files
------------

// File: rtl/pc_pkg.sv
// pc_pkg: next-PC source encoding, step sizes and alignment mask for the fetch PC unit
package pc_pkg;
  typedef enum logic [2:0] {SRC_HOLD, SRC_SEQ, SRC_RET, SRC_BR, SRC_TRAP} next_pc_src_e;
  localparam logic [2:0] PC_STEP4 = 3'd4;
  localparam logic [2:0] PC_STEP2 = 3'd2;
  function automatic logic [1:0] align_mask(input logic c_ext);
    return c_ext ? 2'b01 : 2'b11;
  endfunction
endpackage

// File: rtl/fetch_pc_unit_if.sv
// fetch_pc_if: fetch handshake, redirect requests and RAS controls of the fetch PC unit
interface fetch_pc_if #(parameter int XLEN = 32);
  logic            fetch_valid;
  logic            fetch_ready;
  logic [XLEN-1:0] fetch_pc;
  logic            insn_len16;
  logic            trap_valid;
  logic [XLEN-1:0] trap_vector;
  logic            br_valid;
  logic [XLEN-1:0] br_target;
  logic            call_push;
  logic [XLEN-1:0] call_ret_addr;
  logic            ret_pop;
  logic            ras_empty;
  logic            ret_miss;
  logic            misalign_err;
  modport master (
    output fetch_valid, fetch_pc, ras_empty, ret_miss, misalign_err,
    input  fetch_ready, insn_len16, trap_valid, trap_vector, br_valid, br_target,
           call_push, call_ret_addr, ret_pop
  );
  modport slave (
    input  fetch_valid, fetch_pc, ras_empty, ret_miss, misalign_err,
    output fetch_ready, insn_len16, trap_valid, trap_vector, br_valid, br_target,
           call_push, call_ret_addr, ret_pop
  );
endinterface

// File: rtl/ras_stack.sv
// ras_stack: circular return-address stack with saturating occupancy
module ras_stack #(
  parameter int XLEN      = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  logic [XLEN-1:0] push_data,
  input  logic            pop,
  output logic [XLEN-1:0] top_data,
  output logic            empty,
  output logic            pop_miss
);
  localparam int PW = $clog2(RAS_DEPTH);
  logic [XLEN-1:0] mem [RAS_DEPTH];
  logic [PW-1:0]   tp;
  logic [PW:0]     cnt;
  logic            do_pop;
  assign empty    = cnt == '0;
  assign do_pop   = pop && !empty;
  assign pop_miss = pop && empty;
  assign top_data = mem[tp];
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tp  <= '0;
      cnt <= '0;
    end else if (push && !do_pop) begin
      tp  <= tp + 1'b1;
      cnt <= (cnt == RAS_DEPTH[PW:0]) ? cnt : cnt + 1'b1;
    end else if (do_pop && !push) begin
      tp  <= tp - 1'b1;
      cnt <= cnt - 1'b1;
    end
  end
  // push+pop replaces the old top in place
  always_ff @(posedge clk) begin
    if (push) mem[do_pop ? tp : tp + 1'b1] <= push_data;
  end
endmodule

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: program counter with priority next-PC selection and return prediction
module fetch_pc_unit
  import pc_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              RAS_DEPTH    = 4,
  parameter int              C_EXT        = 0
) (
  input logic        clk,
  input logic        rst_n,
  fetch_pc_if.master bus
);
  next_pc_src_e    src;
  logic [XLEN-1:0] tgt, next_pc, ras_top, pc;
  logic [1:0]      amask;
  logic            hs, empty, pop_miss, mis, valid, ret_miss_q, mis_q;
  ras_stack #(.XLEN(XLEN), .RAS_DEPTH(RAS_DEPTH)) u_ras (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (bus.call_push),
    .push_data (bus.call_ret_addr),
    .pop       (bus.ret_pop),
    .top_data  (ras_top),
    .empty     (empty),
    .pop_miss  (pop_miss)
  );
  assign hs    = valid && bus.fetch_ready;
  assign amask = align_mask(C_EXT != 0);
  always_comb begin
    src = bus.trap_valid ? SRC_TRAP :
          bus.br_valid ? SRC_BR :
          (bus.ret_pop && !empty) ? SRC_RET :
          hs ? SRC_SEQ : SRC_HOLD;
    tgt = bus.trap_valid ? bus.trap_vector : bus.br_target;
    mis = (src == SRC_TRAP || src == SRC_BR) && |(tgt[1:0] & amask);
    next_pc = (src == SRC_TRAP || src == SRC_BR) ? {tgt[XLEN-1:2], tgt[1:0] & ~amask} :
              (src == SRC_RET) ? ras_top :
              (src == SRC_SEQ) ? pc + XLEN'((C_EXT != 0 && bus.insn_len16) ? PC_STEP2 : PC_STEP4) :
              pc;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc         <= RESET_VECTOR;
      valid      <= 1'b0;
      ret_miss_q <= 1'b0;
      mis_q      <= 1'b0;
    end else begin
      pc         <= next_pc;
      valid      <= 1'b1;
      ret_miss_q <= pop_miss;
      mis_q      <= mis;
    end
  end
  assign bus.fetch_pc     = pc;
  assign bus.fetch_valid  = valid;
  assign bus.ras_empty    = empty;
  assign bus.ret_miss     = ret_miss_q;
  assign bus.misalign_err = mis_q;
endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb_fetch_pc_unit: directed checks of two fetch PC units (C_EXT=0 and C_EXT=1) driven in lockstep
module tb_fetch_pc_unit;
  logic        clk = 1'b0;
  logic        rst_n, ready, len16, trap_v, br_v, push, pop;
  logic [31:0] trap_vec, br_t, ra;
  int          checks = 0;
  int          errors = 0;
  always #5 clk = ~clk;
  fetch_pc_if #(.XLEN(32)) if0 ();
  fetch_pc_if #(.XLEN(32)) if1 ();
  assign if0.fetch_ready = ready;    assign if1.fetch_ready = ready;
  assign if0.insn_len16 = len16;     assign if1.insn_len16 = len16;
  assign if0.trap_valid = trap_v;    assign if1.trap_valid = trap_v;
  assign if0.trap_vector = trap_vec; assign if1.trap_vector = trap_vec;
  assign if0.br_valid = br_v;        assign if1.br_valid = br_v;
  assign if0.br_target = br_t;       assign if1.br_target = br_t;
  assign if0.call_push = push;       assign if1.call_push = push;
  assign if0.call_ret_addr = ra;     assign if1.call_ret_addr = ra;
  assign if0.ret_pop = pop;          assign if1.ret_pop = pop;
  fetch_pc_unit #(.XLEN(32), .RESET_VECTOR(32'h100), .RAS_DEPTH(4), .C_EXT(0)) u0 (
    .clk(clk), .rst_n(rst_n), .bus(if0.master));
  fetch_pc_unit #(.XLEN(32), .RESET_VECTOR(32'h100), .RAS_DEPTH(4), .C_EXT(1)) u1 (
    .clk(clk), .rst_n(rst_n), .bus(if1.master));
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  initial begin
    rst_n = 0; ready = 1; len16 = 0; trap_v = 0; br_v = 0; push = 0; pop = 0;
    trap_vec = '0; br_t = '0; ra = '0;
    tick(); tick();
    chk("rst_pc", if0.fetch_pc, 32'h100);
    chk("rst_valid", {31'b0, if0.fetch_valid}, 32'd0);
    chk("rst_empty", {31'b0, if0.ras_empty}, 32'd1);
    chk("rst_miss", {31'b0, if0.ret_miss}, 32'd0);
    chk("rst_mis", {31'b0, if0.misalign_err}, 32'd0);
    rst_n = 1;
    tick();
    chk("rel_valid", {31'b0, if0.fetch_valid}, 32'd1);
    chk("rel_pc", if0.fetch_pc, 32'h100);
    tick(); chk("seq1", if0.fetch_pc, 32'h104);
    tick(); chk("seq2", if0.fetch_pc, 32'h108);
    br_v = 1; br_t = 32'h200;
    tick(); chk("br200", if0.fetch_pc, 32'h200);
    br_v = 0; ready = 0;
    tick(); tick(); tick();
    chk("stall_pc", if0.fetch_pc, 32'h200);
    chk("stall_valid", {31'b0, if0.fetch_valid}, 32'd1);
    ready = 1;
    tick(); chk("unstall", if0.fetch_pc, 32'h204);
    br_v = 1;
    tick(); br_v = 0; len16 = 1;
    tick();
    chk("len16_c0", if0.fetch_pc, 32'h204);
    chk("len16_c1", if1.fetch_pc, 32'h202);
    len16 = 0; push = 1;
    for (int i = 1; i <= 5; i++) begin
      ra = 32'(i * 16);
      tick();
    end
    chk("push_nonempty", {31'b0, if0.ras_empty}, 32'd0);
    push = 0; pop = 1;
    tick(); chk("pop50", if0.fetch_pc, 32'h50);
    tick(); chk("pop40", if0.fetch_pc, 32'h40);
    tick(); chk("pop30", if0.fetch_pc, 32'h30);
    tick(); chk("pop20", if0.fetch_pc, 32'h20);
    chk("pop_empty", {31'b0, if0.ras_empty}, 32'd1);
    tick();
    chk("miss_pulse", {31'b0, if0.ret_miss}, 32'd1);
    chk("miss_seq", if0.fetch_pc, 32'h24);
    pop = 0;
    tick();
    chk("miss_clear", {31'b0, if0.ret_miss}, 32'd0);
    chk("after_miss", if0.fetch_pc, 32'h28);
    push = 1; ra = 32'h30;
    tick(); push = 0;
    trap_v = 1; trap_vec = 32'h800; br_v = 1; br_t = 32'h400; pop = 1;
    tick();
    chk("prio_trap", if0.fetch_pc, 32'h800);
    chk("prio_popped", {31'b0, if0.ras_empty}, 32'd1);
    trap_v = 0; br_v = 0; pop = 0;
    push = 1; ra = 32'hA0;
    tick();
    ra = 32'hB0; pop = 1;
    tick();
    chk("pushpop_tgt", if0.fetch_pc, 32'hA0);
    chk("pushpop_cnt", {31'b0, if0.ras_empty}, 32'd0);
    push = 0;
    tick();
    chk("pushpop_new", if0.fetch_pc, 32'hB0);
    chk("pushpop_empty", {31'b0, if0.ras_empty}, 32'd1);
    pop = 0; br_v = 1; br_t = 32'h403;
    tick();
    chk("mis_pc_c0", if0.fetch_pc, 32'h400);
    chk("mis_pc_c1", if1.fetch_pc, 32'h402);
    chk("mis_err_c0", {31'b0, if0.misalign_err}, 32'd1);
    chk("mis_err_c1", {31'b0, if1.misalign_err}, 32'd1);
    br_v = 0;
    tick();
    chk("mis_clear", {31'b0, if0.misalign_err}, 32'd0);
    chk("mis_seq_c1", if1.fetch_pc, 32'h406);
    br_v = 1; br_t = 32'h402;
    tick();
    chk("half_c0", if0.fetch_pc, 32'h400);
    chk("half_err_c0", {31'b0, if0.misalign_err}, 32'd1);
    chk("half_c1", if1.fetch_pc, 32'h402);
    chk("half_err_c1", {31'b0, if1.misalign_err}, 32'd0);
    br_t = 32'hFFFF_FFFC;
    tick(); br_v = 0;
    tick();
    chk("wrap", if0.fetch_pc, 32'h0);
    chk("wrap_noerr", {31'b0, if0.misalign_err}, 32'd0);
    push = 1; ra = 32'h60;
    tick(); ra = 32'h70;
    tick(); push = 0;
    rst_n = 0; br_v = 1; br_t = 32'h400;
    tick();
    chk("midrst_pc", if0.fetch_pc, 32'h100);
    chk("midrst_valid", {31'b0, if0.fetch_valid}, 32'd0);
    chk("midrst_empty", {31'b0, if0.ras_empty}, 32'd1);
    rst_n = 1; br_v = 0;
    tick();
    chk("midrst_rel", if0.fetch_pc, 32'h100);
    pop = 1;
    tick();
    chk("midrst_miss", {31'b0, if0.ret_miss}, 32'd1);
    chk("midrst_seq", if0.fetch_pc, 32'h104);
    pop = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
